pipeline_decode_rf: RTL and testbench
=====================================

Name: pipeline_decode_rf

Overview:
- Parametrised ID stage for the RV32 pipeline: owns the integer register file and decodes the instruction delivered by the fetch stage.
- Generates the immediate for every base format (I/S/B/U/J) and reads both source operands with write-back bypass.
- Registers the decoded bundle into the ID/EX pipeline register under a valid/stall/flush handshake.
- Sits between pipeline fetch and execute; write-back drives the write port.

Parameters:
XLEN, 32, datapath and register width (32 or 64)
NUM_REGS, 32, architectural registers (16 for RV32E, 32 otherwise)
REG_AW, 5, register address width; upper bits of an rs/rd field outside NUM_REGS read as x0
RESET_PC, 0, value of pc_o after reset

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  asynchronous active-low reset
in_valid_i  in  1  instruction_i/pc_i hold a valid instruction
instruction_i  in  32  instruction from fetch
pc_i  in  XLEN  PC of instruction_i
stall_i  in  1  hold ID/EX register (hazard unit)
flush_i  in  1  squash ID/EX register (branch/jump redirect)
reg_write_i  in  1  write-back enable
write_reg_i  in  REG_AW  write-back address
write_data_i  in  XLEN  write-back data
valid_o  out  1  ID/EX bundle valid
pc_o  out  XLEN  registered PC
rs1_o, rs2_o, rd_o  out  REG_AW each  instr[19:15], [24:20], [11:7]
opcode_o  out  7  instr[6:0]
funct3_o  out  3  instr[14:12]
funct7_o  out  7  instr[31:25]
read_data1_o, read_data2_o  out  XLEN each  operand values
imm_o  out  XLEN  sign-extended immediate
illegal_o  out  1  opcode not in the supported set

Behaviour:
- Reset (rst_ni low, async): every output 0, except pc_o = RESET_PC. All register-file entries cleared to 0.
- Register file:
  - Write on rising edge when reg_write_i=1 and write_reg_i != 0 and write_reg_i < NUM_REGS.
  - x0 always reads 0; writes to x0 or to out-of-range addresses are ignored.
- Read/bypass (combinational, same cycle):
  - If reg_write_i=1, write_reg_i == rsN, and rsN != 0, the operand is write_data_i; otherwise it is the register-file entry.
- Immediate selection by opcode, sign-extended from instr[31] to XLEN:
  - I: 0000011, 0010011, 1100111, 1110011 -> instr[31:20]
  - S: 0100011 -> {instr[31:25], instr[11:7]}
  - B: 1100011 -> {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: 0110111, 0010111 -> {instr[31:12], 12'b0}
  - J: 1101111 -> {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R: 0110011 -> imm 0
  - Any other opcode -> imm 0, illegal_o = 1.
- ID/EX register update, priority order:
  1. flush_i=1: valid_o <= 0; all other outputs hold. Flush wins over stall.
  2. stall_i=1: all fields hold.
     - Exception: if reg_write_i=1, write_reg_i != 0, and write_reg_i equals the held rs1_o (resp. rs2_o), read_data1_o (resp. read_data2_o) <= write_data_i, so a stalled consumer picks up the late write-back.
  3. Otherwise: valid_o <= in_valid_i, and all fields are captured from the current decode.
     - When in_valid_i=0, only valid_o changes; data fields hold.
- Latency: one cycle, instruction_i -> ID/EX outputs.
- Reset mid-stall or mid-flush: reset dominates; the next edge after release behaves as a normal capture.
- XLEN=64: immediates sign-extended to 64 bits; no RV64-only opcodes are added (illegal_o set for them).

Test Plan:
- Reset then write x5=0xDEADBEEF; on next edge decode add x1,x5,x0 (0x000280B3) -> read_data1_o=0xDEADBEEF, read_data2_o=0, rd_o=1, imm_o=0, valid_o=1.
- Same-cycle bypass: reg_write_i=1, write_reg_i=3, write_data_i=0x55 while decoding sw x3,-4(x2) (0xFE312E23) -> read_data2_o=0x55, imm_o=0xFFFFFFFC.
- Write to x0 with 0x1234, then read x0 -> read_data1_o=0. Also with NUM_REGS=16, write to x20 is ignored and reading x20 returns 0.
- Immediates: beq x0,x0,-8 (0xFE000CE3) -> imm_o=0xFFFFFFF8. lui x1,0x12345 (0x123450B7) -> imm_o=0x12345000. jal x1,+2048 (0x001000EF) -> imm_o=0x00000800. Opcode 0x7F -> illegal_o=1, imm_o=0.
- Stall update: capture rs1=7, hold stall_i=1 for 3 cycles, write x7=0xA5A5 in cycle 2 -> read_data1_o=0xA5A5 and all other fields unchanged. Assert stall_i and flush_i together -> valid_o=0.
- Assert rst_ni low asynchronously between edges with valid_o=1 -> outputs zero immediately and pc_o=RESET_PC; x5 then reads 0.

Source files
------------

// File: rtl/pipeline_decode_rf.sv
// RV32 ID stage: integer register file, instruction decode,
// immediate generation and the ID/EX pipeline register.
module pipeline_decode_rf #(
  parameter int XLEN = 32,
  parameter int NUM_REGS = 32,
  parameter int REG_AW = 5,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic [31:0]       instruction_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              reg_write_i,
  input  logic [REG_AW-1:0] write_reg_i,
  input  logic [XLEN-1:0]   write_data_i,
  output logic              valid_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [REG_AW-1:0] rs1_o,
  output logic [REG_AW-1:0] rs2_o,
  output logic [REG_AW-1:0] rd_o,
  output logic [6:0]        opcode_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic [XLEN-1:0]   read_data1_o,
  output logic [XLEN-1:0]   read_data2_o,
  output logic [XLEN-1:0]   imm_o,
  output logic              illegal_o
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [XLEN-1:0] rf [NUM_REGS];

  logic [31:0]       ins;
  logic [6:0]        op;
  logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;
  logic              we;
  logic [XLEN-1:0]   rf1, rf2, rd1_d, rd2_d;
  logic              is_i, is_s, is_b, is_u, is_j, is_r;
  logic [31:0]       imm32;
  logic [XLEN-1:0]   imm_d;
  logic              ill_d;

  function automatic logic in_rng(input logic [REG_AW-1:0] a);
    return 32'(a) < 32'(NUM_REGS);
  endfunction

  assign ins   = instruction_i;
  assign op    = ins[6:0];
  assign rs1_d = REG_AW'(ins[19:15]);
  assign rs2_d = REG_AW'(ins[24:20]);
  assign rd_d  = REG_AW'(ins[11:7]);

  assign we = reg_write_i && (write_reg_i != '0)
           && in_rng(write_reg_i);

  // Register file storage; x0 is never written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (we) begin
      rf[write_reg_i[IW-1:0]] <= write_data_i;
    end
  end

  assign rf1 = (rs1_d != '0 && in_rng(rs1_d))
             ? rf[rs1_d[IW-1:0]] : '0;
  assign rf2 = (rs2_d != '0 && in_rng(rs2_d))
             ? rf[rs2_d[IW-1:0]] : '0;

  assign rd1_d = (reg_write_i && write_reg_i == rs1_d
                  && rs1_d != '0) ? write_data_i : rf1;
  assign rd2_d = (reg_write_i && write_reg_i == rs2_d
                  && rs2_d != '0) ? write_data_i : rf2;

  assign is_i = (op == 7'b0000011) || (op == 7'b0010011)
             || (op == 7'b1100111) || (op == 7'b1110011);
  assign is_s = (op == 7'b0100011);
  assign is_b = (op == 7'b1100011);
  assign is_u = (op == 7'b0110111) || (op == 7'b0010111);
  assign is_j = (op == 7'b1101111);
  assign is_r = (op == 7'b0110011);

  // Immediate format select; unknown opcodes flag illegal.
  always_comb begin
    imm32 = '0;
    ill_d = 1'b0;
    unique case (1'b1)
      is_i: imm32 = {{20{ins[31]}}, ins[31:20]};
      is_s: imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      is_b: imm32 = {{19{ins[31]}}, ins[31], ins[7],
                     ins[30:25], ins[11:8], 1'b0};
      is_u: imm32 = {ins[31:12], 12'b0};
      is_j: imm32 = {{11{ins[31]}}, ins[31], ins[19:12],
                     ins[20], ins[30:21], 1'b0};
      is_r: imm32 = '0;
      default: ill_d = 1'b1;
    endcase
  end

  assign imm_d = XLEN'($signed(imm32));

  // ID/EX register: flush > stall > capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o      <= 1'b0;
      pc_o         <= RESET_PC;
      rs1_o        <= '0;
      rs2_o        <= '0;
      rd_o         <= '0;
      opcode_o     <= '0;
      funct3_o     <= '0;
      funct7_o     <= '0;
      read_data1_o <= '0;
      read_data2_o <= '0;
      imm_o        <= '0;
      illegal_o    <= 1'b0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (stall_i) begin
      if (reg_write_i && write_reg_i != '0
          && write_reg_i == rs1_o)
        read_data1_o <= write_data_i;
      if (reg_write_i && write_reg_i != '0
          && write_reg_i == rs2_o)
        read_data2_o <= write_data_i;
    end else begin
      valid_o <= in_valid_i;
      if (in_valid_i) begin
        pc_o         <= pc_i;
        rs1_o        <= rs1_d;
        rs2_o        <= rs2_d;
        rd_o         <= rd_d;
        opcode_o     <= op;
        funct3_o     <= ins[14:12];
        funct7_o     <= ins[31:25];
        read_data1_o <= rd1_d;
        read_data2_o <= rd2_d;
        imm_o        <= imm_d;
        illegal_o    <= ill_d;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_decode_rf.sv
// Bench for pipeline_decode_rf: directed cases plus random
// traffic against an arithmetic reference model.
module tb_pipeline_decode_rf;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        stall, flush, rw;
  logic [4:0]  wr;
  logic [31:0] wd;

  logic        valid, ill;
  logic [31:0] pc_q, rd1, rd2, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;

  logic        e_valid, e_ill;
  logic [31:0] e_pc, e_rd1, e_rd2, e_imm;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic [6:0]  e_opc, e_f7;
  logic [2:0]  e_f3;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_rf [32];
  logic        m_valid, m_ill;
  logic [31:0] m_pc, m_rd1, m_rd2, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [6:0]  m_opc, m_f7;
  logic [2:0]  m_f3;

  always #5 clk = ~clk;

  pipeline_decode_rf #(.RESET_PC(RPC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid),
    .instruction_i(instr), .pc_i(pc), .stall_i(stall),
    .flush_i(flush), .reg_write_i(rw), .write_reg_i(wr),
    .write_data_i(wd), .valid_o(valid), .pc_o(pc_q),
    .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd), .opcode_o(opc),
    .funct3_o(f3), .funct7_o(f7), .read_data1_o(rd1),
    .read_data2_o(rd2), .imm_o(imm), .illegal_o(ill)
  );

  pipeline_decode_rf #(.NUM_REGS(16)) u_e (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid),
    .instruction_i(instr), .pc_i(pc), .stall_i(stall),
    .flush_i(flush), .reg_write_i(rw), .write_reg_i(wr),
    .write_data_i(wd), .valid_o(e_valid), .pc_o(e_pc),
    .rs1_o(e_rs1), .rs2_o(e_rs2), .rd_o(e_rd),
    .opcode_o(e_opc), .funct3_o(e_f3), .funct7_o(e_f7),
    .read_data1_o(e_rd1), .read_data2_o(e_rd2),
    .imm_o(e_imm), .illegal_o(e_ill)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] i,
                                          output logic bad);
    int s;
    s = $signed(i);
    bad = 1'b0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: return s >>> 20;
      7'h23: return (s >>> 25) * 32 + int'(i[11:7]);
      7'h63: return (s >>> 31) * 4096 + int'(i[7]) * 2048
                  + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      7'h37, 7'h17: return i & 32'hFFFF_F000;
      7'h6F: return (s >>> 31) * 1048576
                  + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
                  + int'(i[30:21]) * 2;
      7'h33: return 32'h0;
      default: begin
        bad = 1'b1;
        return 32'h0;
      end
    endcase
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (rw && wr == r) return wd;
    return m_rf[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_valid = 0; m_pc = RPC; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_opc = 0; m_f3 = 0; m_f7 = 0; m_rd1 = 0; m_rd2 = 0;
    m_imm = 0; m_ill = 0;
  endtask

  task automatic model_edge();
    logic b;
    if (flush) begin
      m_valid = 0;
    end else if (stall) begin
      if (rw && wr != 0 && wr == m_rs1) m_rd1 = wd;
      if (rw && wr != 0 && wr == m_rs2) m_rd2 = wd;
    end else begin
      m_valid = in_valid;
      if (in_valid) begin
        m_pc = pc;
        m_rs1 = instr[19:15];
        m_rs2 = instr[24:20];
        m_rd = instr[11:7];
        m_opc = instr[6:0];
        m_f3 = instr[14:12];
        m_f7 = instr[31:25];
        m_rd1 = operand(m_rs1);
        m_rd2 = operand(m_rs2);
        m_imm = ref_imm(instr, b);
        m_ill = b;
      end
    end
    if (rw && wr != 0) m_rf[wr] = wd;
  endtask

  task automatic check_all();
    chk("valid", valid, m_valid);
    chk("pc", pc_q, m_pc);
    chk("rs1", rs1, m_rs1);
    chk("rs2", rs2, m_rs2);
    chk("rd", rd, m_rd);
    chk("opcode", opc, m_opc);
    chk("funct3", f3, m_f3);
    chk("funct7", f7, m_f7);
    chk("rdata1", rd1, m_rd1);
    chk("rdata2", rd2, m_rd2);
    chk("imm", imm, m_imm);
    chk("illegal", ill, m_ill);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    in_valid = 0; instr = 0; pc = 0; stall = 0; flush = 0;
    rw = 0; wr = 0; wd = 0;
  endtask

  task automatic dec(input logic [31:0] i, input logic [31:0] p);
    idle();
    in_valid = 1; instr = i; pc = p;
  endtask

  logic [6:0] ops [12];
  logic [31:0] r;

  initial begin
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
            7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h0B};
    idle();
    rst_n = 0;
    model_reset();
    #12;
    check_all();
    chk("e_rst_valid", e_valid, 1'b0);
    @(negedge clk);
    rst_n = 1;

    rw = 1; wr = 5; wd = 32'hDEAD_BEEF;
    step();
    dec(32'h0002_80B3, 32'h40);
    step();
    chk("add_rd1", rd1, 32'hDEAD_BEEF);
    chk("add_rd2", rd2, 32'h0);
    chk("add_rd", rd, 5'd1);
    chk("add_valid", valid, 1'b1);

    dec(32'hFE31_2E23, 32'h44);
    rw = 1; wr = 3; wd = 32'h55;
    step();
    chk("sw_bypass", rd2, 32'h55);
    chk("sw_imm", imm, 32'hFFFF_FFFC);

    idle();
    rw = 1; wr = 0; wd = 32'h1234;
    step();
    dec(32'h0000_00B3, 32'h48);
    step();
    chk("x0_read", rd1, 32'h0);

    idle();
    rw = 1; wr = 20; wd = 32'h777;
    step();
    dec(32'h000A_00B3, 32'h4C);
    step();
    chk("x20_rv32", rd1, 32'h777);
    chk("x20_rv32e", e_rd1, 32'h0);

    dec(32'hFE00_0CE3, 32'h50);
    step();
    chk("beq_imm", imm, 32'hFFFF_FFF8);
    dec(32'h1234_50B7, 32'h54);
    step();
    chk("lui_imm", imm, 32'h1234_5000);
    dec(32'h0010_00EF, 32'h58);
    step();
    chk("jal_imm", imm, 32'h0000_0800);
    dec(32'h0000_007F, 32'h5C);
    step();
    chk("bad_ill", ill, 1'b1);
    chk("bad_imm", imm, 32'h0);

    dec(32'h0003_8133, 32'h60);
    step();
    for (int c = 1; c <= 3; c++) begin
      dec(32'hFE31_2E23, 32'h64);
      stall = 1;
      if (c == 2) begin
        rw = 1; wr = 7; wd = 32'hA5A5;
      end
      step();
    end
    chk("stall_rd1", rd1, 32'hA5A5);
    chk("stall_pc", pc_q, 32'h60);
    chk("stall_rs1", rs1, 5'd7);
    stall = 1; flush = 1;
    step();
    chk("flush_valid", valid, 1'b0);

    dec(32'h0002_80B3, 32'h70);
    step();
    chk("pre_rst_valid", valid, 1'b1);
    #3 rst_n = 0;
    #1;
    model_reset();
    check_all();
    chk("async_pc", pc_q, RPC);
    #2 rst_n = 1;
    dec(32'h0002_80B3, 32'h74);
    step();
    chk("x5_cleared", rd1, 32'h0);

    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      in_valid = ($urandom_range(0, 3) != 0);
      instr = {r[31:7], ops[$urandom_range(0, 11)]};
      pc = $urandom() & 32'hFFFF_FFFC;
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      rw = $urandom_range(0, 1);
      wr = 5'($urandom_range(0, 31));
      wd = $urandom();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
